// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data-memory handshake,
// stalls upstream while an access is outstanding, and aligns/extends load data.
module mem_access_stage #(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 5,
    parameter int ISIZE   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [1:0]       size_in,
    input  logic             unsigned_in,
    input  logic [DSIZE-1:0] result_in,
    input  logic [DSIZE-1:0] wdata_in,
    input  logic             wen_in,
    input  logic             mem_to_reg_in,
    input  logic             jal_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ISIZE-1:0] PC_jal_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DSIZE-1:0] dmem_rdata,
    output logic             wen_out,
    output logic             mem_to_reg_out,
    output logic             jal_out,
    output logic [DSIZE-1:0] result_out,
    output logic [DSIZE-1:0] rdata_mem_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [ISIZE-1:0] PC_jal_out,
    output logic             stall_out,
    output logic             misalign_err,
    output logic             bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]       off;
    logic             is_byte, is_half, is_word;
    logic             mem_op, misaligned, access;
    logic             req, stall, ack_done, timeout, mis_flag;
    logic [3:0]       be;
    logic [DSIZE-1:0] wdata_rep;
    logic [DSIZE-1:0] load_ext;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    assign off     = result_in[1:0];
    assign is_byte = (size_in == 2'b00);
    assign is_half = (size_in == 2'b01);
    assign is_word = size_in[1];

    always_comb begin
        mem_op     = valid_in & (mem_read_in | mem_write_in);
        misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
        access     = mem_op & ~misaligned;
    end

    // Handshake sequencing; in BUSY the upstream is frozen so the request is
    // simply held at 1 from the stable inputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        ack_done = 1'b0;
        timeout  = 1'b0;
        mis_flag = 1'b0;
        case (state_q)
            IDLE: begin
                req      = access;
                mis_flag = mem_op & misaligned;
                if (access) begin
                    if (dmem_ack) begin
                        ack_done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CW'(1);
                    end
                end
            end
            BUSY: begin
                req = 1'b1;
                if (dmem_ack) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = is_byte ? (off == 2'(gi)) :
                            is_half ? (off[1] == (gi >= 2)) : 1'b1;
            assign wdata_rep[8*gi +: 8] = is_byte ? wdata_in[7:0] :
                                          is_half ? wdata_in[8*(gi%2) +: 8] :
                                                    wdata_in[8*gi +: 8];
        end
    endgenerate

    // Little-endian lane pick, then sign or zero extension.
    always_comb begin
        byte_v = dmem_rdata[8*off +: 8];
        half_v = dmem_rdata[16*off[1] +: 16];
        if (is_byte) begin
            load_ext = {{(DSIZE-8){~unsigned_in & byte_v[7]}}, byte_v};
        end else if (is_half) begin
            load_ext = {{(DSIZE-16){~unsigned_in & half_v[15]}}, half_v};
        end else begin
            load_ext = dmem_rdata;
        end
    end

    assign dmem_req       = ~rst & req;
    assign dmem_we        = ~rst & mem_write_in;
    assign dmem_addr      = rst ? '0 : {result_in[DSIZE-1:2], 2'b00};
    assign dmem_be        = rst ? 4'b0000 : be;
    assign dmem_wdata     = rst ? '0 : wdata_rep;
    assign stall_out      = ~rst & stall;
    assign misalign_err   = ~rst & mis_flag;
    assign bus_err        = ~rst & timeout;
    assign wen_out        = ~rst & valid_in & wen_in & ~mem_write_in & ~stall & ~mis_flag & ~timeout;
    assign jal_out        = ~rst & jal_in & ~stall & ~mis_flag;
    assign mem_to_reg_out = ~rst & mem_to_reg_in;
    assign result_out     = rst ? '0 : result_in;
    assign waddr_out      = rst ? '0 : waddr_in;
    assign PC_jal_out     = rst ? '0 : PC_jal_in;
    assign rdata_mem_out  = (~rst & ack_done) ? load_ext : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized + directed bench for mem_access_stage against a transaction-level
// model: each access is described by its ack latency, not by FSM state.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in, mem_read_in, mem_write_in, unsigned_in;
    logic [1:0]  size_in;
    logic [31:0] result_in, wdata_in, dmem_rdata;
    logic        wen_in, mem_to_reg_in, jal_in, dmem_ack;
    logic [4:0]  waddr_in;
    logic [31:0] PC_jal_in;
    logic        dmem_req, dmem_we, wen_out, mem_to_reg_out, jal_out;
    logic [31:0] dmem_addr, dmem_wdata, result_out, rdata_mem_out, PC_jal_out;
    logic [3:0]  dmem_be;
    logic [4:0]  waddr_out;
    logic        stall_out, misalign_err, bus_err;

    always #5 clk = ~clk;

    mem_access_stage #(.DSIZE(32), .ASIZE(5), .ISIZE(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .size_in(size_in), .unsigned_in(unsigned_in),
        .result_in(result_in), .wdata_in(wdata_in), .wen_in(wen_in),
        .mem_to_reg_in(mem_to_reg_in), .jal_in(jal_in), .waddr_in(waddr_in),
        .PC_jal_in(PC_jal_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wen_out(wen_out),
        .mem_to_reg_out(mem_to_reg_out), .jal_out(jal_out), .result_out(result_out),
        .rdata_mem_out(rdata_mem_out), .waddr_out(waddr_out), .PC_jal_out(PC_jal_out),
        .stall_out(stall_out), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction description
    logic        t_valid, t_rd, t_wr, t_uns, t_wen, t_m2r, t_jal;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata, t_rdata, t_pc;
    logic [4:0]  t_waddr;

    // Observations captured during the last transaction
    int          obs_stall_cycles;
    logic        obs_req_any, obs_mis_any, obs_bus_any, obs_last_wen;
    logic [31:0] obs_last_rdata, obs_first_addr, obs_first_wdata;
    logic [3:0]  obs_first_be;

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'b0001 << (a % 4);
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        logic [31:0] b, h;
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        if (sz == 2'd0) return b * 32'h01010101;
        if (sz == 2'd1) return h * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic [31:0] rd, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic drive_inputs(input logic ack);
        valid_in = t_valid; mem_read_in = t_rd; mem_write_in = t_wr;
        size_in = t_size; unsigned_in = t_uns; result_in = t_addr;
        wdata_in = t_wdata; wen_in = t_wen; mem_to_reg_in = t_m2r;
        jal_in = t_jal; waddr_in = t_waddr; PC_jal_in = t_pc;
        dmem_rdata = t_rdata; dmem_ack = ack;
    endtask

    // lat = stall cycles before ack; lat > TO means the memory never answers.
    task automatic run_txn(input int lat);
        logic mop, mis, acc, ack;
        logic e_req, e_stall, e_wen, e_jal, e_mis, e_bus;
        logic [31:0] e_rd;
        int ncyc;
        mop  = t_valid & (t_rd | t_wr);
        mis  = mop & m_misaligned(t_size, t_addr);
        acc  = mop & ~mis;
        ncyc = !acc ? 1 : ((lat <= TO) ? lat + 1 : TO + 1);
        obs_stall_cycles = 0;
        obs_req_any = 0; obs_mis_any = 0; obs_bus_any = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            rst = 1'b0;
            ack = acc ? (k == lat) : 1'($urandom_range(0, 1));
            drive_inputs(ack);
            #1;
            e_rd = 32'h0; e_bus = 1'b0; e_mis = 1'b0;
            if (!acc) begin
                e_req = 1'b0; e_stall = 1'b0; e_mis = mis;
                e_wen = mis ? 1'b0 : (t_valid & t_wen);
                e_jal = mis ? 1'b0 : t_jal;
            end else if (k < ncyc - 1) begin
                e_req = 1'b1; e_stall = 1'b1; e_wen = 1'b0; e_jal = 1'b0;
            end else if (lat <= TO) begin
                e_req = 1'b1; e_stall = 1'b0; e_wen = t_wen & ~t_wr; e_jal = t_jal;
                e_rd = m_load(t_size, t_addr, t_rdata, t_uns);
            end else begin
                e_req = 1'b1; e_stall = 1'b0; e_wen = 1'b0; e_jal = t_jal; e_bus = 1'b1;
            end
            check_val("req",      32'(dmem_req),       32'(e_req));
            check_val("stall",    32'(stall_out),      32'(e_stall));
            check_val("wen",      32'(wen_out),        32'(e_wen));
            check_val("jal",      32'(jal_out),        32'(e_jal));
            check_val("rdata",    rdata_mem_out,       e_rd);
            check_val("misalign", 32'(misalign_err),   32'(e_mis));
            check_val("bus_err",  32'(bus_err),        32'(e_bus));
            check_val("addr",     dmem_addr,           t_addr & 32'hFFFFFFFC);
            check_val("be",       32'(dmem_be),        32'(m_be(t_size, t_addr)));
            check_val("wdata",    dmem_wdata,          m_wdata(t_size, t_wdata));
            check_val("we",       32'(dmem_we),        32'(t_wr));
            check_val("result",   result_out,          t_addr);
            check_val("waddr",    32'(waddr_out),      32'(t_waddr));
            check_val("pc_jal",   PC_jal_out,          t_pc);
            check_val("m2r",      32'(mem_to_reg_out), 32'(t_m2r));
            if (stall_out) obs_stall_cycles++;
            obs_req_any |= dmem_req;
            obs_mis_any |= misalign_err;
            obs_bus_any |= bus_err;
            obs_last_rdata = rdata_mem_out;
            obs_last_wen   = wen_out;
            if (k == 0) begin
                obs_first_addr = dmem_addr; obs_first_be = dmem_be; obs_first_wdata = dmem_wdata;
            end
        end
        $display("txn v=%0b rd=%0b wr=%0b sz=%0d addr=%h lat=%0d cycles=%0d stall=%0d rdata_out=%h",
                 t_valid, t_rd, t_wr, t_size, t_addr, lat, ncyc, obs_stall_cycles, obs_last_rdata);
    endtask

    task automatic set_txn(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdv);
        t_valid = v; t_rd = rd; t_wr = wr; t_size = sz; t_uns = uns; t_addr = a;
        t_wdata = wd; t_rdata = rdv; t_wen = ~wr; t_m2r = rd; t_jal = 1'b0;
        t_waddr = 5'd7; t_pc = 32'h0000_4000;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   32'(dmem_req),  32'h0);
        check_val({tag, "_stall"}, 32'(stall_out), 32'h0);
        check_val({tag, "_wen"},   32'(wen_out),   32'h0);
        check_val({tag, "_bus"},   32'(bus_err),   32'h0);
        check_val({tag, "_mis"},   32'(misalign_err), 32'h0);
        check_val({tag, "_res"},   result_out,     32'h0);
        check_val({tag, "_rdata"}, rdata_mem_out,  32'h0);
        check_val({tag, "_be"},    32'(dmem_be),   32'h0);
    endtask

    initial begin
        int lat, kind, r;
        set_txn(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        t_jal = 1'b1;
        drive_inputs(1'b1);

        // Reset holds every output low even with a live load and ack present
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive_inputs(1'b1);
            #1;
            check_all_zero("reset");
        end
        $display("txn reset held 2 cycles");

        set_txn(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        run_txn(0);
        check_val("lw0_rdata", obs_last_rdata, 32'hDEADBEEF);
        check_val("lw0_stall", 32'(obs_stall_cycles), 32'd0);
        check_val("lw0_wen",   32'(obs_last_wen), 32'd1);

        set_txn(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0011);
        run_txn(3);
        check_val("lb_stall", 32'(obs_stall_cycles), 32'd3);
        check_val("lb_rdata", obs_last_rdata, 32'hFFFFFF80);
        set_txn(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0011);
        run_txn(3);
        check_val("lbu_rdata", obs_last_rdata, 32'h00000080);

        set_txn(1, 0, 1, 2'd1, 0, 32'h0A, 32'h1234ABCD, 32'h0);
        run_txn(0);
        check_val("sh_be",    32'(obs_first_be), 32'hC);
        check_val("sh_wdata", obs_first_wdata, 32'hABCDABCD);
        check_val("sh_addr",  obs_first_addr, 32'h08);
        check_val("sh_wen",   32'(obs_last_wen), 32'd0);

        set_txn(1, 1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0);
        run_txn(0);
        check_val("mis_flag", 32'(obs_mis_any), 32'd1);
        check_val("mis_req",  32'(obs_req_any), 32'd0);

        set_txn(1, 1, 0, 2'd2, 0, 32'h200, 32'h0, 32'h11223344);
        run_txn(TO + 5);
        check_val("to_stall", 32'(obs_stall_cycles), 32'(TO));
        check_val("to_bus",   32'(obs_bus_any), 32'd1);
        check_val("to_wen",   32'(obs_last_wen), 32'd0);
        run_txn(0);  // FSM must be back in IDLE: zero-wait completion
        check_val("to_after", obs_last_rdata, 32'h11223344);

        set_txn(1, 1, 0, 2'd2, 0, 32'h204, 32'h0, 32'hCAFEF00D);
        run_txn(TO);  // ack coincides with the timeout cycle
        check_val("ack_at_to_rdata", obs_last_rdata, 32'hCAFEF00D);
        check_val("ack_at_to_bus",   32'(obs_bus_any), 32'd0);

        // Reset during the second BUSY cycle drops the access
        set_txn(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h55AA55AA);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = (k == 2);
            drive_inputs(1'b0);
            #1;
            if (k < 2) check_val("rb_stall", 32'(stall_out), 32'd1);
            else       check_all_zero("rb_rst");
        end
        set_txn(0, 0, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_inputs(1'b0);
        #1;
        check_val("rb_req",   32'(dmem_req), 32'd0);
        check_val("rb_stall0", 32'(stall_out), 32'd0);
        $display("txn reset in BUSY, access dropped");
        set_txn(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h0BADF00D);
        run_txn(0);
        check_val("rb_lw", obs_last_rdata, 32'h0BADF00D);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 2);
            set_txn(1'($urandom_range(0, 9) != 0), kind == 0, kind == 1,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom);
            t_wen = 1'($urandom_range(0, 1)); t_m2r = 1'($urandom_range(0, 1));
            t_jal = 1'($urandom_range(0, 1)); t_waddr = 5'($urandom_range(0, 31));
            t_pc = $urandom;
            if ($urandom_range(0, 2) != 0 && t_size != 2'd0) begin
                t_addr[0] = 1'b0;
                if (t_size[1]) t_addr[1] = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r <= 5)      lat = r;
            else if (r == 6) lat = TO - 1;
            else if (r == 7) lat = TO;
            else if (r == 8) lat = TO + 1;
            else             lat = $urandom_range(6, TO - 2);
            run_txn(lat);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
